// File: rtl/target_dispatcher.sv
// Round-robin dispatcher: one target-sequence stream fanned out to MODULES feeder/scoring pairs.
// Optional length screening of held words via `define TARGET_DISPATCHER_LEN_CHECK_EN.
module target_dispatcher #(
  parameter int MODULES       = 2,
  parameter int ID_WIDTH      = 48,
  parameter int LEN_WIDTH     = 12,
  parameter int TARGET_LENGTH = 128,
  parameter int IN_WIDTH      = ID_WIDTH + LEN_WIDTH + 2*TARGET_LENGTH,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_last,
  input  logic [MODULES-1:0]   full,
  input  logic [MODULES-1:0]   res_vld,
  output logic [MODULES-1:0]   ld,
  output logic [IN_WIDTH-1:0]  feed_out,
  output logic [CNT_WIDTH-1:0] issued,
  output logic [CNT_WIDTH-1:0] retired,
  output logic                 busy,
  output logic                 all_done,
  output logic                 err
);
  localparam int PTR_W = (MODULES > 1) ? $clog2(MODULES) : 1;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DISPATCH = 2'd1;
  localparam logic [1:0] S_DRAIN    = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  logic [1:0]           state;
  logic                 hold_valid;
  logic [IN_WIDTH-1:0]  hold_data;
  logic                 last_seen;
  logic [PTR_W-1:0]     ptr;
  logic [MODULES-1:0]   mask;

  logic [MODULES-1:0]   cand;
  logic [MODULES-1:0]   sel_oh;
  logic [PTR_W-1:0]     sel;
  logic [PTR_W-1:0]     ptr_nxt;
  logic                 found;
  logic                 dispatching;
  logic                 counting;
  logic                 len_bad;
  logic                 issue;
  logic                 discard;
  logic                 accept;
  logic [CNT_WIDTH-1:0] res_cnt;
  logic [CNT_WIDTH-1:0] outstanding;
  logic                 over;
  logic [CNT_WIDTH-1:0] ret_add;

  assign dispatching = (state == S_DISPATCH);
  assign counting    = (state == S_DISPATCH) || (state == S_DRAIN);
  assign busy        = counting;
  assign all_done    = (state == S_DONE);

  // Masking the just-loaded feeder for a cycle hides its full-flag latency.
  assign cand = ~full & ~mask;

  always_comb begin
    int idx;
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int i = 0; i < MODULES; i++) begin
      idx = (int'(ptr) + i) % MODULES;
      if (!found && cand[idx]) begin
        found = 1'b1;
        sel   = PTR_W'(idx);
      end
    end
    sel_oh = found ? (MODULES'(1) << sel) : '0;
  end

  assign ptr_nxt = (sel == PTR_W'(MODULES-1)) ? '0 : sel + 1'b1;

`ifdef TARGET_DISPATCHER_LEN_CHECK_EN
  logic [LEN_WIDTH-1:0] hold_len;
  assign hold_len = hold_data[2*TARGET_LENGTH +: LEN_WIDTH];
  assign len_bad  = (hold_len == '0) || (hold_len > LEN_WIDTH'(TARGET_LENGTH));
`else
  assign len_bad  = 1'b0;
`endif

  assign issue    = hold_valid & dispatching & ~len_bad & found;
  assign discard  = hold_valid & dispatching & len_bad;
  assign in_ready = dispatching & ~last_seen & (~hold_valid | issue | discard);
  assign accept   = in_valid & in_ready;

  always_comb begin
    res_cnt = '0;
    for (int i = 0; i < MODULES; i++)
      res_cnt = res_cnt + CNT_WIDTH'(res_vld[i]);
  end

  // A result may retire a target issued in this very cycle; extra pulses are dropped.
  assign outstanding = issued + CNT_WIDTH'(issue) - retired;
  assign over        = counting && (res_cnt > outstanding);
  assign ret_add     = !counting ? '0 : (over ? outstanding : res_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      last_seen  <= 1'b0;
      ptr        <= '0;
      mask       <= '0;
      ld         <= '0;
      feed_out   <= '0;
      issued     <= '0;
      retired    <= '0;
      err        <= 1'b0;
    end else begin
      ld   <= '0;
      mask <= '0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_DISPATCH;
            issued     <= '0;
            retired    <= '0;
            err        <= 1'b0;
            last_seen  <= 1'b0;
            ptr        <= '0;
            hold_valid <= 1'b0;
          end
        end
        S_DISPATCH: begin
          if (last_seen && !hold_valid && (ld == '0))
            state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (issued == retired)
            state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase

      if (issue) begin
        ld       <= sel_oh;
        mask     <= sel_oh;
        feed_out <= hold_data;
        ptr      <= ptr_nxt;
        issued   <= issued + 1'b1;
      end

      if (accept) begin
        hold_valid <= 1'b1;
        hold_data  <= in_data;
        if (in_last) last_seen <= 1'b1;
      end else if (issue || discard) begin
        hold_valid <= 1'b0;
      end

      if (counting) retired <= retired + ret_add;
      if (over || discard) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_target_dispatcher.sv
// Bench for target_dispatcher: cycle tables, directed corner sequences and a scoreboarded random run.
module tb_target_dispatcher;
  localparam int M  = 2;
  localparam int IW = 48 + 12 + 256;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, in_last;
  logic          in_ready, busy, all_done, err;
  logic [IW-1:0] in_data, feed_out;
  logic [M-1:0]  full, res_vld, ld;
  logic [15:0]   issued, retired;

  int checks = 0;
  int errors = 0;

  target_dispatcher dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .full(full), .res_vld(res_vld), .ld(ld),
    .feed_out(feed_out), .issued(issued), .retired(retired), .busy(busy),
    .all_done(all_done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst, start, vld, last;
    bit [47:0] id;
    bit [1:0] full, res;
    bit e_rdy;
    bit [1:0] e_ld;
    bit [47:0] e_id;
    int e_iss, e_ret;
    bit e_busy, e_done, e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit s, bit v, bit [47:0] id, bit l, bit [1:0] f, bit [1:0] rv,
                              bit rdy, bit [1:0] eld, bit [47:0] eid, int iss, int ret,
                              bit b, bit d, bit e);
    vec_t x;
    x.rst = r; x.start = s; x.vld = v; x.id = id; x.last = l; x.full = f; x.res = rv;
    x.e_rdy = rdy; x.e_ld = eld; x.e_id = eid; x.e_iss = iss; x.e_ret = ret;
    x.e_busy = b; x.e_done = d; x.e_err = e;
    return x;
  endfunction

  function automatic logic [IW-1:0] mk_word(logic [47:0] id, logic [11:0] len, logic [255:0] bases);
    return {id, len, bases};
  endfunction

  function automatic logic [IW-1:0] rand_word();
    logic [255:0] b;
    for (int i = 0; i < 8; i++) b[i*32 +: 32] = $urandom;
    return mk_word({16'($urandom), $urandom}, 12'($urandom_range(1, 128)), b);
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_word(string nm, logic [IW-1:0] act, logic [IW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(bit v, logic [IW-1:0] w, bit l, bit [1:0] f, bit [1:0] rv);
    @(negedge clk);
    in_valid = v; in_data = w; in_last = l; full = f; res_vld = rv;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; start = 0; in_valid = 0; in_last = 0; in_data = '0; full = '0; res_vld = '0;
    step(); step();
    rst = 0;
  endtask

  task automatic start_run();
    @(negedge clk);
    start = 1;
    step();
    start = 0;
    chk("start busy", 64'(busy), 64'(1));
  endtask

  task automatic apply(vec_t v, int n);
    @(negedge clk);
    rst = v.rst; start = v.start; in_valid = v.vld; in_last = v.last;
    in_data = mk_word(v.id, 12'd64, {8{v.id[31:0]}}); full = v.full; res_vld = v.res;
    #1;
    chk($sformatf("row%0d in_ready", n), 64'(in_ready), 64'(v.e_rdy));
    step();
    chk($sformatf("row%0d ld", n), 64'(ld), 64'(v.e_ld));
    if (v.e_ld != 0) chk($sformatf("row%0d feed id", n), 64'(feed_out[IW-1 -: 48]), 64'(v.e_id));
    if (v.rst) chk($sformatf("row%0d feed_out", n), 64'(feed_out != '0), 64'(0));
    chk($sformatf("row%0d issued", n), 64'(issued), 64'(v.e_iss));
    chk($sformatf("row%0d retired", n), 64'(retired), 64'(v.e_ret));
    chk($sformatf("row%0d busy", n), 64'(busy), 64'(v.e_busy));
    chk($sformatf("row%0d all_done", n), 64'(all_done), 64'(v.e_done));
    chk($sformatf("row%0d err", n), 64'(err), 64'(v.e_err));
  endtask

  initial begin
    rst = 1; start = 0; in_valid = 0; in_last = 0; in_data = '0; full = '0; res_vld = '0;

    do_reset();
    chk("reset ld", 64'(ld), 64'(0));
    chk("reset feed_out", 64'(feed_out != '0), 64'(0));
    chk("reset in_ready", 64'(in_ready), 64'(0));
    chk("reset issued", 64'(issued), 64'(0));
    chk("reset retired", 64'(retired), 64'(0));
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset all_done", 64'(all_done), 64'(0));
    chk("reset err", 64'(err), 64'(0));

    // free-running alternation, drain, restart, spurious result, mid-run reset
    tbl.push_back(mk(0,1,0,48'h0,0,2'b00,2'b00, 0,2'b00,48'h0, 0,0,1,0,0));
    tbl.push_back(mk(0,0,1,48'h0,0,2'b00,2'b00, 1,2'b00,48'h0, 0,0,1,0,0));
    tbl.push_back(mk(0,0,1,48'h1,0,2'b00,2'b00, 1,2'b01,48'h0, 1,0,1,0,0));
    tbl.push_back(mk(0,0,1,48'h2,0,2'b00,2'b00, 1,2'b10,48'h1, 2,0,1,0,0));
    tbl.push_back(mk(0,0,1,48'h3,1,2'b00,2'b00, 1,2'b01,48'h2, 3,0,1,0,0));
    tbl.push_back(mk(0,0,0,48'h0,0,2'b00,2'b00, 0,2'b10,48'h3, 4,0,1,0,0));
    tbl.push_back(mk(0,0,0,48'h0,0,2'b00,2'b00, 0,2'b00,48'h0, 4,0,1,0,0));
    tbl.push_back(mk(0,0,0,48'h0,0,2'b00,2'b00, 0,2'b00,48'h0, 4,0,1,0,0));
    tbl.push_back(mk(0,0,0,48'h0,0,2'b00,2'b11, 0,2'b00,48'h0, 4,2,1,0,0));
    tbl.push_back(mk(0,0,0,48'h0,0,2'b00,2'b01, 0,2'b00,48'h0, 4,3,1,0,0));
    tbl.push_back(mk(0,0,0,48'h0,0,2'b00,2'b01, 0,2'b00,48'h0, 4,4,1,0,0));
    tbl.push_back(mk(0,0,0,48'h0,0,2'b00,2'b00, 0,2'b00,48'h0, 4,4,0,1,0));
    tbl.push_back(mk(0,1,0,48'h0,0,2'b00,2'b00, 0,2'b00,48'h0, 0,0,1,0,0));
    tbl.push_back(mk(0,0,0,48'h0,0,2'b00,2'b01, 1,2'b00,48'h0, 0,0,1,0,1));
    tbl.push_back(mk(1,0,0,48'h0,0,2'b00,2'b00, 1,2'b00,48'h0, 0,0,0,0,0));
    // feeder 0 stuck full: every word goes to feeder 1 on alternate cycles
    tbl.push_back(mk(0,1,0,48'h0,0,2'b01,2'b00, 0,2'b00,48'h0, 0,0,1,0,0));
    tbl.push_back(mk(0,0,1,48'h10,0,2'b01,2'b00, 1,2'b00,48'h0, 0,0,1,0,0));
    tbl.push_back(mk(0,0,1,48'h11,0,2'b01,2'b00, 1,2'b10,48'h10, 1,0,1,0,0));
    tbl.push_back(mk(0,0,1,48'h12,0,2'b01,2'b00, 0,2'b00,48'h0, 1,0,1,0,0));
    tbl.push_back(mk(0,0,1,48'h12,0,2'b01,2'b00, 1,2'b10,48'h11, 2,0,1,0,0));
    tbl.push_back(mk(0,0,1,48'h13,1,2'b01,2'b00, 0,2'b00,48'h0, 2,0,1,0,0));
    tbl.push_back(mk(0,0,1,48'h13,1,2'b01,2'b00, 1,2'b10,48'h12, 3,0,1,0,0));
    tbl.push_back(mk(0,0,0,48'h0,0,2'b01,2'b00, 0,2'b00,48'h0, 3,0,1,0,0));
    tbl.push_back(mk(0,0,0,48'h0,0,2'b01,2'b00, 0,2'b10,48'h13, 4,0,1,0,0));
    tbl.push_back(mk(0,0,0,48'h0,0,2'b01,2'b00, 0,2'b00,48'h0, 4,0,1,0,0));

    do_reset();
    foreach (tbl[i]) apply(tbl[i], i);

    // all feeders full: word held, nothing loaded, then released to feeder 1
    do_reset();
    start_run();
    drive(1, mk_word(48'h55, 12'd64, '1), 0, 2'b11, 2'b00);
    chk("allfull accept", 64'(in_ready), 64'(1));
    step();
    for (int k = 0; k < 5; k++) begin
      drive(1, mk_word(48'h56, 12'd64, '0), 0, 2'b11, 2'b00);
      chk($sformatf("allfull%0d in_ready", k), 64'(in_ready), 64'(0));
      step();
      chk($sformatf("allfull%0d ld", k), 64'(ld), 64'(0));
    end
    drive(1, mk_word(48'h56, 12'd64, '0), 0, 2'b01, 2'b00);
    chk("release in_ready", 64'(in_ready), 64'(1));
    step();
    chk("release ld", 64'(ld), 64'(2'b10));
    chk("release id", 64'(feed_out[IW-1 -: 48]), 64'(48'h55));

`ifdef TARGET_DISPATCHER_LEN_CHECK_EN
    do_reset();
    start_run();
    drive(1, mk_word(48'hA0, 12'd0, '0), 0, 2'b00, 2'b00);
    step();
    drive(1, mk_word(48'hA1, 12'd129, '0), 0, 2'b00, 2'b00);
    chk("len0 in_ready", 64'(in_ready), 64'(1));
    step();
    chk("len0 ld", 64'(ld), 64'(0));
    chk("len0 err", 64'(err), 64'(1));
    chk("len0 issued", 64'(issued), 64'(0));
    drive(1, mk_word(48'hA2, 12'd64, '0), 0, 2'b00, 2'b00);
    step();
    chk("len129 ld", 64'(ld), 64'(0));
    chk("len129 issued", 64'(issued), 64'(0));
    drive(0, '0, 0, 2'b00, 2'b00);
    step();
    chk("len64 ld", 64'(ld), 64'(2'b01));
    chk("len64 id", 64'(feed_out[IW-1 -: 48]), 64'(48'hA2));
    chk("len64 issued", 64'(issued), 64'(1));
`endif

    // random run against an ordered scoreboard
    begin
      int N;
      int sent, nld, mret, outst, pc;
      bit have;
      logic [IW-1:0] cur;
      logic [IW-1:0] q[$];
      logic [1:0] prev_ld, cur_full, rv;
      N = 60; sent = 0; nld = 0; mret = 0; have = 0; prev_ld = '0; cur = '0;
      do_reset();
      start_run();
      for (int cyc = 0; cyc < 3000 && !(nld == N && mret == N); cyc++) begin
        if (!have && sent < N && ($urandom % 4) != 0) begin
          cur = rand_word();
          have = 1;
        end
        rv = '0;
        outst = nld - mret;
        for (int i = 0; i < M; i++)
          if (outst > 0 && ($urandom % 3) == 0) begin rv[i] = 1'b1; outst--; end
        cur_full = 2'($urandom);
        drive(have, cur, (sent == N-1), cur_full, rv);
        if (in_valid && in_ready) begin
          q.push_back(cur);
          have = 0;
          sent++;
        end
        step();
        pc = int'(rv[0]) + int'(rv[1]);
        mret += pc;
        if (ld != '0) begin
          chk("rand ld onehot", 64'($onehot(ld)), 64'(1));
          chk("rand ld to full feeder", 64'(ld & cur_full), 64'(0));
          chk("rand back-to-back reload", 64'(ld & prev_ld), 64'(0));
          if (q.size() > 0) chk_word("rand feed_out order", feed_out, q.pop_front());
          else chk("rand unexpected ld", 64'(ld), 64'(0));
          nld++;
        end
        prev_ld = ld;
        chk("rand issued", 64'(issued), 64'(nld));
        chk("rand retired", 64'(retired), 64'(mret));
        chk("rand err", 64'(err), 64'(0));
      end
      chk("rand all loaded", 64'(nld), 64'(N));
      chk("rand all retired", 64'(mret), 64'(N));
      drive(0, '0, 0, 2'b00, 2'b00);
      for (int k = 0; k < 10 && !all_done; k++) step();
      chk("rand all_done", 64'(all_done), 64'(1));
      chk("rand busy clear", 64'(busy), 64'(0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
